// File: rtl/wb_arb2_if.sv
// Wishbone classic bus bundle for one master/slave link.
// dat_w flows master->slave, dat_r flows slave->master.
interface wb_arb2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  we;
  logic                  stb;
  logic                  cyc;
  logic                  ack;
  logic                  err;

  modport master (output adr, dat_w, we, stb, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, cyc, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter, grant held for the whole cyc tenure, round-robin on ties.
// Define WB_ARB_TIMEOUT_EN to add the ACK watchdog that aborts stuck slave accesses.
module wb_arb2 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  wb_arb2_if.slave    m0,
  wb_arb2_if.slave    m1,
  wb_arb2_if.master   s,
  output logic [1:0]  o_grant
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arb2: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_d;
  logic   last_gnt;
  logic   own0, own1;
  logic   aborted, to;

  logic [ADDR_WIDTH-1:0] adr_sel;
  logic [DATA_WIDTH-1:0] dat_sel;
  logic                  we_sel, stb_sel, cyc_sel;

  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_d;
      if (state_d == GNT0) last_gnt <= 1'b0;
      if (state_d == GNT1) last_gnt <= 1'b1;
    end
  end

  // Release goes straight to the other master if it is waiting: no idle bubble.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_gnt)) state_d = GNT0;
        else if (m1.cyc)                     state_d = GNT1;
      end
      GNT0: if (!m0.cyc) state_d = m1.cyc ? GNT1 : IDLE;
      GNT1: if (!m1.cyc) state_d = m0.cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adr_sel = '0;
    dat_sel = '0;
    we_sel  = 1'b0;
    stb_sel = 1'b0;
    cyc_sel = 1'b0;
    if (own0) begin
      adr_sel = m0.adr; dat_sel = m0.dat_w; we_sel = m0.we; stb_sel = m0.stb; cyc_sel = m0.cyc;
    end else if (own1) begin
      adr_sel = m1.adr; dat_sel = m1.dat_w; we_sel = m1.we; stb_sel = m1.stb; cyc_sel = m1.cyc;
    end
  end

  assign s.adr   = adr_sel;
  assign s.dat_w = dat_sel;
  assign s.we    = we_sel;
  assign s.cyc   = cyc_sel & ~aborted;
  assign s.stb   = stb_sel & ~aborted;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign to = (own0 | own1) && (cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      aborted <= 1'b0;
    end else if (state_d != state) begin
      cnt     <= '0;
      aborted <= 1'b0;
    end else if (to) begin
      cnt     <= '0;
      aborted <= 1'b1;
    end else if (s.stb && !s.ack) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign to      = 1'b0;
  assign aborted = 1'b0;
`endif

  // An ACK coinciding with the error pulse is dropped so a master never sees both.
  assign m0.ack   = own0 & s.ack & ~aborted & ~to;
  assign m1.ack   = own1 & s.ack & ~aborted & ~to;
  assign m0.dat_r = own0 ? s.dat_r : '0;
  assign m1.dat_r = own1 ? s.dat_r : '0;
  assign m0.err   = own0 & to;
  assign m1.err   = own1 & to;
  assign o_grant  = {own1, own0};

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: directed scenarios plus randomized traffic against a tenure-level model.
module tb_wb_arb2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] o_grant;
  bit         chk_on = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 i_clk = ~i_clk;

  wb_arb2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  wb_arb2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();
  wb_arb2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_bus ();

  wb_arb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .o_grant(o_grant)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner (0 none, 1 m0, 2 m1), who won last, waiting-cycle count, abort flag.
  int own, last, wait_cnt;
  bit ab;

  function automatic bit m_to();
`ifdef WB_ARB_TIMEOUT_EN
    return own != 0 && wait_cnt == TO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit e_stb();
    if (ab) return 1'b0;
    return own == 1 ? m0_bus.stb : own == 2 ? m1_bus.stb : 1'b0;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      own = 0; last = 1; wait_cnt = 0; ab = 1'b0;
    end else begin
      int nxt;
      bit mine, other, tnow;
      tnow = m_to();
      nxt  = own;
      if (own == 0) begin
        if (m0_bus.cyc && m1_bus.cyc) nxt = (last == 1) ? 1 : 2;
        else if (m0_bus.cyc)          nxt = 1;
        else if (m1_bus.cyc)          nxt = 2;
      end else begin
        mine  = (own == 1) ? m0_bus.cyc : m1_bus.cyc;
        other = (own == 1) ? m1_bus.cyc : m0_bus.cyc;
        if (!mine) nxt = other ? 3 - own : 0;
      end
      if (nxt != own)                  begin wait_cnt = 0; ab = 1'b0; end
      else if (tnow)                   begin wait_cnt = 0; ab = 1'b1; end
      else if (e_stb() && !s_bus.ack)  wait_cnt++;
      else                             wait_cnt = 0;
      if (nxt == 1) last = 0;
      if (nxt == 2) last = 1;
      own = nxt;
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      bit tnow;
      logic [AW-1:0] eadr;
      logic [DW-1:0] edat;
      bit ewe, ecyc;
      tnow = m_to();
      eadr = own == 1 ? m0_bus.adr   : own == 2 ? m1_bus.adr   : '0;
      edat = own == 1 ? m0_bus.dat_w : own == 2 ? m1_bus.dat_w : '0;
      ewe  = own == 1 ? m0_bus.we    : own == 2 ? m1_bus.we    : 1'b0;
      ecyc = !ab && (own == 1 ? m0_bus.cyc : own == 2 ? m1_bus.cyc : 1'b0);
      chk("grant", o_grant, own == 1 ? 2'b01 : own == 2 ? 2'b10 : 2'b00);
      chk("s_cyc", s_bus.cyc, ecyc);
      chk("s_stb", s_bus.stb, e_stb());
      chk("s_adr", s_bus.adr, eadr);
      chk("s_dat", s_bus.dat_w, edat);
      chk("s_we",  s_bus.we, ewe);
      chk("m0_ack", m0_bus.ack, own == 1 && s_bus.ack && !ab && !tnow);
      chk("m1_ack", m1_bus.ack, own == 2 && s_bus.ack && !ab && !tnow);
      chk("m0_dat", m0_bus.dat_r, own == 1 ? s_bus.dat_r : '0);
      chk("m1_dat", m1_bus.dat_r, own == 2 ? s_bus.dat_r : '0);
      chk("m0_err", m0_bus.err, own == 1 && tnow);
      chk("m1_err", m1_bus.err, own == 2 && tnow);
    end
  end

  task automatic step(); @(posedge i_clk); #1; endtask
  task automatic samp(); @(negedge i_clk); endtask

  task automatic drv0(input bit c, input bit st, input logic [AW-1:0] a);
    m0_bus.cyc = c; m0_bus.stb = st; m0_bus.adr = a;
  endtask
  task automatic drv1(input bit c, input bit st, input logic [AW-1:0] a);
    m1_bus.cyc = c; m1_bus.stb = st; m1_bus.adr = a;
  endtask

  initial begin
    drv0(0, 0, '0); drv1(0, 0, '0);
    m0_bus.we = 0; m1_bus.we = 0; m0_bus.dat_w = 32'h1111_0000; m1_bus.dat_w = 32'h2222_0000;
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF; s_bus.err = 1'b0;
    #1 chk_on = 1'b1;
    samp;
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_m0_ack", m0_bus.ack, 1'b0);
    chk("rst_m0_dat", m0_bus.dat_r, 32'h0);
    step; i_rst_n = 1'b1; s_bus.ack = 1'b0; s_bus.dat_r = '0;

    // tie from reset: m0 first, direct handoff, m0 again on next tie
    step; drv0(1, 1, 32'h20); drv1(1, 1, 32'h30);
    step; samp; chk("t2_tie0", o_grant, 2'b01); chk("t2_adr0", s_bus.adr, 32'h20);
    step; drv0(0, 0, 32'h0);
    step; samp; chk("t2_handoff", o_grant, 2'b10); chk("t2_adr1", s_bus.adr, 32'h30);
    step; drv1(0, 0, 32'h0);
    step; samp; chk("t2_idle", o_grant, 2'b00);
    step; drv0(1, 1, 32'h24); drv1(1, 1, 32'h34);
    step; samp; chk("t2_tie1", o_grant, 2'b01);
    step; drv0(0, 0, 0); drv1(0, 0, 0);
    step;

    // single master read, ACK two cycles after grant
    step; drv0(1, 1, 32'h10);
    samp; chk("t1_pre", o_grant, 2'b00);
    step; samp; chk("t1_grant", o_grant, 2'b01); chk("t1_stb", s_bus.stb, 1'b1);
    step; samp; chk("t1_wait_ack", m0_bus.ack, 1'b0);
    step; s_bus.ack = 1; s_bus.dat_r = 32'hDEADBEEF;
    samp; chk("t1_ack", m0_bus.ack, 1'b1); chk("t1_dat", m0_bus.dat_r, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_bus.ack, 1'b0);
    step; s_bus.ack = 0; drv0(0, 0, 0);
    step; samp; chk("t1_idle", o_grant, 2'b00);

    // m1 burst holds the grant while m0 waits
    step; drv1(1, 1, 32'h200);
    step; drv0(1, 1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      m1_bus.adr = 32'h200 + 32'(4 * i); s_bus.ack = 1'b1;
      samp; chk("t3_adr", s_bus.adr, 32'h200 + 32'(4 * i)); chk("t3_m0_ack", m0_bus.ack, 1'b0);
      step;
    end
    s_bus.ack = 1'b0; drv1(0, 0, 0);
    step; samp; chk("t3_m0_grant", o_grant, 2'b01); chk("t3_m0_adr", s_bus.adr, 32'h100);
    step; drv0(0, 0, 0);
    step;

    // async reset mid-tenure
    step; drv1(1, 1, 32'h300);
    step; samp; chk("t4_grant", o_grant, 2'b10);
    step; s_bus.ack = 1'b1;
    #2 i_rst_n = 1'b0;
    #1 chk("t4_s_cyc", s_bus.cyc, 1'b0); chk("t4_grant0", o_grant, 2'b00); chk("t4_m1_ack", m1_bus.ack, 1'b0);
    #3 i_rst_n = 1'b1; s_bus.ack = 1'b0;
    step; samp; chk("t4_regrant", o_grant, 2'b10);
    step; drv1(0, 0, 0);
    step;

`ifdef WB_ARB_TIMEOUT_EN
    // slave never ACKs: one-cycle err after TO waiting cycles, then bus cut
    step; drv0(1, 1, 32'h40);
    step;
    for (int i = 0; i < TO; i++) begin
      samp; chk("t5_err_early", m0_bus.err, 1'b0);
      step;
    end
    samp; chk("t5_err", m0_bus.err, 1'b1);
    step; s_bus.ack = 1'b1;
    samp; chk("t5_err_once", m0_bus.err, 1'b0); chk("t5_s_cyc", s_bus.cyc, 1'b0);
    chk("t5_late_ack", m0_bus.ack, 1'b0);
    step; s_bus.ack = 1'b0; drv0(0, 0, 0);
    step;
`endif

    for (int i = 0; i < 2000; i++) begin
      step;
      if (m0_bus.cyc) m0_bus.cyc = ($urandom % 4) != 0;
      else            m0_bus.cyc = ($urandom % 3) == 0;
      if (m1_bus.cyc) m1_bus.cyc = ($urandom % 4) != 0;
      else            m1_bus.cyc = ($urandom % 3) == 0;
      m0_bus.stb = m0_bus.cyc && ($urandom % 4 != 0);
      m1_bus.stb = m1_bus.cyc && ($urandom % 4 != 0);
      m0_bus.adr = $urandom; m1_bus.adr = $urandom;
      m0_bus.dat_w = $urandom; m1_bus.dat_w = $urandom;
      m0_bus.we = 1'($urandom); m1_bus.we = 1'($urandom);
      s_bus.ack = ($urandom % 3) == 0;
      s_bus.dat_r = $urandom;
      if (i % 500 == 250) begin
        #2 i_rst_n = 1'b0;
        #4 i_rst_n = 1'b1;
      end
    end
    step;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
